rename_wide: RTL and testbench
==============================

Name: rename_wide

Overview:
- Superscalar register-rename stage between decode and dispatch; renames up to WIDTH instructions per cycle.
- Intra-group RAW/WAW bypass: a later lane's source reads, and its old-dest reads, see an earlier lane's new allocation.
- Accepts multiple commit frees per cycle.
- Branch checkpoints live in an ordered circular queue, so recovery can target any in-flight checkpoint.

Parameters:
- WIDTH, 2, instructions renamed per cycle.
- N_LOG, 32, logical registers.
- N_PHYS, 96, physical registers; need not be a power of two.
- N_CKPT, 8, checkpoint queue depth.
- COMMIT_W, 2, commit frees per cycle.
- ROB_TAG_W, 7, ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dec_valid_i  in  WIDTH  per-lane valid.
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  WIDTH x 5  logical register indices.
- dec_rs1_used_i, dec_rs2_used_i, dec_rd_used_i, dec_is_branch_i  in  WIDTH  per-lane flags.
- dec_payload_i  in  WIDTH x ctrl_payload_t  passthrough payload.
- dec_ready_o  out  1  group accepted this cycle.
- ren_valid_o  out  WIDTH  per-lane output valid.
- ren_ready_i  in  1  dispatch accepts the whole group.
- rs1_p_o, rs2_p_o, rd_new_p_o, rd_old_p_o  out  WIDTH x PREG_W  physical registers.
- rob_tag_o  out  WIDTH x ROB_TAG_W  ROB tags.
- ckpt_id_o  out  WIDTH x CKPT_W  checkpoint id; valid on branch lanes only.
- payload_o  out  WIDTH x ctrl_payload_t  registered payload.
- commit_valid_i  in  COMMIT_W  commit free valid.
- commit_preg_i  in  COMMIT_W x PREG_W  physical register being freed.
- recover_i  in  1  mispredict recovery request.
- recover_ckpt_i  in  CKPT_W  checkpoint to restore.
- resolve_i  in  1  oldest checkpoint resolved correct; release it.

Behaviour:
- Reset state:
  - map[i] = i.
  - Free list holds pregs N_LOG..N_PHYS-1; fl_head = 0, fl_tail = N_PHYS-N_LOG, fl_count = N_PHYS-N_LOG.
  - rob_tag = 0; checkpoint queue empty.
  - All outputs 0, ren_valid_o = 0, dec_ready_o = 0.
  - Reset mid-operation discards all in-flight state.
- A lane needs allocation iff valid && rd_used && rd != 0.
  - n_alloc = count of lanes needing allocation.
  - n_br = count of valid lanes with dec_is_branch_i.
- accept = any dec_valid && (!out_valid || ren_ready_i) && n_alloc <= fl_count && n_br <= free checkpoint slots && !recover_i.
  - dec_ready_o = accept.
  - Acceptance is all-or-nothing per group; there is no partial acceptance.
- Latency: 1 cycle, registered outputs.
  - ren_valid_o[l] = dec_valid_i[l] of the accepted group.
  - The output group holds while !ren_ready_i.
  - Output clears on handshake when no new group is accepted.
- Lane l renaming, in lane order:
  - Sources and old dest use the map updated by lanes 0..l-1 in the same group.
  - rd_new = next free-list entry in lane order.
  - Unused sources output 0. Non-allocating lanes: rd_old = 0 if !rd_used; rd_new = rd_old.
- ROB tags: consecutive per valid lane in lane order, wrapping mod 2^ROB_TAG_W. Invalid lanes consume no tag.
- Free-list pointers wrap explicitly at N_PHYS (not 2^PREG_W).
  - Pops: n_alloc from head. Pushes: up to COMMIT_W at tail, in port order.
  - commit_preg == 0 is ignored.
  - Pushes and pops in the same cycle are both applied: fl_count += pushes - pops.
- Checkpoint per branch lane, allocated at queue tail:
  - Captures the map after that lane's own rename, fl_head after that lane's allocation, and the next rob_tag.
  - ckpt_id_o gives the slot.
- resolve_i pops the checkpoint queue head. It is ignored if the queue is empty.
- recover_i with recover_ckpt_i = k:
  - Restores map, fl_head and rob_tag from slot k.
  - Checkpoint queue tail becomes k+1; slot k is kept until it is resolved.
  - fl_tail is never restored. fl_count is recomputed from the restored head and the current tail, including same-cycle commit pushes.
  - Output valid clears; no accept that cycle.
  - A recover_ckpt_i that does not name a live slot is illegal; behaviour is undefined and flagged by an assertion.
- resolve_i and recover_i in the same cycle: both apply. The resolved slot must be older than k.
- Full/empty conditions:
  - Free list empty with n_alloc > 0 -> stall.
  - Checkpoint queue full with n_br > 0 -> stall.
  - Stalls keep dec_ready_o = 0 with no state change.

Decomposition:
- Shared package pipeline_types holds:
  - ctrl_payload_t;
  - preg_t, PREG_W = $clog2(N_PHYS);
  - ckpt_id_t, CKPT_W;
  - rob_tag_t;
  - checkpoint struct rename_ckpt_t (map, fl_head, rob_tag).
- Sub-module rename_freelist: multi-pop/multi-push circular free list with non-power-of-two wrap and a head-restore port.

Test Plan:
- Reset, then group {lane0 add x5, lane1 add x6 = x5+x1} -> lane0 rd_new = 32, lane0 rd_old = 5; lane1 rs1_p = 32 (bypass), lane1 rd_new = 33; tags 0 and 1.
- Same rd in both lanes (x7, x7) -> lane1 rd_old = lane0 rd_new; final map[7] = lane1 rd_new.
- Drain the free list to 1 entry, then present a group with 2 allocations -> dec_ready_o = 0 and state unchanged. Commit 1 preg that cycle -> the group is accepted the next cycle.
- Branch in lane0, a rename in lane1, then recover_i with k = 0 -> map excludes the lane1 write; rob_tag = 1; fl_count is correct including a same-cycle commit of preg 40.
- Fill 8 checkpoints, then present a branch -> stall. resolve_i -> branch accepted and gets ckpt_id 0 after wrap.
- Free-list wrap: 200 alloc/commit cycles with N_PHYS = 96 -> fl_head and fl_tail wrap 95->0, no preg is duplicated, and preg 0 is never handed out.

Source files
------------

// File: rtl/rename_wide_pkg.sv
// Shared rename-stage types: geometry, physical/logical register ids, ROB tags and checkpoints.
// Checkpoint ids rely on N_CKPT being a power of two; free-list pointers wrap explicitly.
package pipeline_types;

  localparam int unsigned WIDTH     = 2;
  localparam int unsigned N_LOG     = 32;
  localparam int unsigned N_PHYS    = 96;
  localparam int unsigned N_CKPT    = 8;
  localparam int unsigned COMMIT_W  = 2;
  localparam int unsigned ROB_TAG_W = 7;

  localparam int unsigned PREG_W   = $clog2(N_PHYS);
  localparam int unsigned LREG_W   = $clog2(N_LOG);
  localparam int unsigned CKPT_W   = $clog2(N_CKPT);
  localparam int unsigned FL_CNT_W = $clog2(N_PHYS + 1);
  localparam int unsigned CQ_CNT_W = $clog2(N_CKPT + 1);
  localparam int unsigned ALLOC_W  = $clog2(WIDTH + 1);

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [LREG_W-1:0]    lreg_t;
  typedef logic [CKPT_W-1:0]    ckpt_id_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } ctrl_payload_t;

  typedef struct packed {
    preg_t [N_LOG-1:0] map;
    preg_t             fl_head;
    rob_tag_t          rob_tag;
  } rename_ckpt_t;

  // Advance a free-list pointer by n (n < N_PHYS), wrapping at N_PHYS.
  function automatic preg_t fl_wrap(preg_t ptr, int unsigned n);
    int unsigned sum;
    sum = 32'(ptr) + n;
    if (sum >= N_PHYS) sum = sum - N_PHYS;
    return preg_t'(sum);
  endfunction

endpackage

// File: rtl/rename_wide_freelist.sv
// Circular free list of physical registers: up to WIDTH pops and COMMIT_W pushes per cycle,
// wrap at N_PHYS, and a head-restore port used by branch recovery.
module rename_freelist
  import pipeline_types::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ALLOC_W-1:0]          pop_cnt,
  output preg_t [WIDTH-1:0]           pop_preg,
  input  logic [COMMIT_W-1:0]         push_valid,
  input  preg_t [COMMIT_W-1:0]        push_preg,
  input  logic                        restore,
  input  preg_t                       restore_head,
  output preg_t                       head,
  output logic [FL_CNT_W-1:0]         count
);

  preg_t                 mem_q [N_PHYS];
  preg_t                 head_q, head_d, tail_q, tail_d;
  logic [FL_CNT_W-1:0]   count_q, count_d, n_push;
  logic [COMMIT_W-1:0]   push_en;
  preg_t [COMMIT_W-1:0]  push_idx;

  always_comb begin
    tail_d   = tail_q;
    n_push   = '0;
    push_en  = '0;
    push_idx = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      // preg 0 backs x0 and must never re-enter the list.
      if (push_valid[j] && push_preg[j] != '0) begin
        push_en[j]  = 1'b1;
        push_idx[j] = tail_d;
        tail_d      = fl_wrap(tail_d, 1);
        n_push      = n_push + FL_CNT_W'(1);
      end
    end
    if (restore) begin
      head_d  = restore_head;
      count_d = (tail_d >= restore_head) ? FL_CNT_W'(tail_d - restore_head)
                                         : FL_CNT_W'(32'(tail_d) + N_PHYS - 32'(restore_head));
    end else begin
      head_d  = fl_wrap(head_q, 32'(pop_cnt));
      count_d = count_q + n_push - FL_CNT_W'(pop_cnt);
    end
  end

  always_comb begin
    for (int l = 0; l < WIDTH; l++) pop_preg[l] = mem_q[fl_wrap(head_q, l)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= preg_t'(N_PHYS - N_LOG);
      count_q <= FL_CNT_W'(N_PHYS - N_LOG);
      for (int i = 0; i < N_PHYS; i++) begin
        mem_q[i] <= (i < N_PHYS - N_LOG) ? preg_t'(i + N_LOG) : '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < COMMIT_W; j++) begin
        if (push_en[j]) mem_q[push_idx[j]] <= push_preg[j];
      end
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/rename_wide.sv
// Superscalar rename stage: WIDTH lanes per cycle with intra-group bypass, multi-commit frees
// and an ordered checkpoint queue that supports recovery to any live checkpoint.
module rename_wide
  import pipeline_types::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               dec_valid_i,
  input  lreg_t [WIDTH-1:0]              dec_rs1_i,
  input  lreg_t [WIDTH-1:0]              dec_rs2_i,
  input  lreg_t [WIDTH-1:0]              dec_rd_i,
  input  logic [WIDTH-1:0]               dec_rs1_used_i,
  input  logic [WIDTH-1:0]               dec_rs2_used_i,
  input  logic [WIDTH-1:0]               dec_rd_used_i,
  input  logic [WIDTH-1:0]               dec_is_branch_i,
  input  ctrl_payload_t [WIDTH-1:0]      dec_payload_i,
  output logic                           dec_ready_o,
  output logic [WIDTH-1:0]               ren_valid_o,
  input  logic                           ren_ready_i,
  output preg_t [WIDTH-1:0]              rs1_p_o,
  output preg_t [WIDTH-1:0]              rs2_p_o,
  output preg_t [WIDTH-1:0]              rd_new_p_o,
  output preg_t [WIDTH-1:0]              rd_old_p_o,
  output rob_tag_t [WIDTH-1:0]           rob_tag_o,
  output ckpt_id_t [WIDTH-1:0]           ckpt_id_o,
  output ctrl_payload_t [WIDTH-1:0]      payload_o,
  input  logic [COMMIT_W-1:0]            commit_valid_i,
  input  preg_t [COMMIT_W-1:0]           commit_preg_i,
  input  logic                           recover_i,
  input  ckpt_id_t                       recover_ckpt_i,
  input  logic                           resolve_i
);

  preg_t [N_LOG-1:0]        map_q, map_next;
  rob_tag_t                 rob_tag_q;
  rename_ckpt_t             ckpt_q [N_CKPT];
  ckpt_id_t                 cq_head_q, cq_head_d, cq_tail_q, cq_tail_d;
  logic [CQ_CNT_W-1:0]      cq_count_q, cq_count_d;
  preg_t                    fl_head;
  logic [FL_CNT_W-1:0]      fl_count;
  preg_t [WIDTH-1:0]        fl_pop_preg;
  logic [ALLOC_W-1:0]       fl_pop_cnt;
  int unsigned              n_alloc, n_valid, n_br;
  preg_t [WIDTH-1:0]        rs1_p_d, rs2_p_d, rd_new_d, rd_old_d;
  rob_tag_t [WIDTH-1:0]     tag_d;
  ckpt_id_t [WIDTH-1:0]     ckpt_id_d;
  logic [WIDTH-1:0]         ckpt_we;
  rename_ckpt_t [WIDTH-1:0] ckpt_new;
  logic                     accept, resolve_ok, recover_live;

  // Lanes are renamed in order against a running copy of the map so later lanes see bypass.
  always_comb begin
    map_next  = map_q;
    n_alloc   = 0;
    n_valid   = 0;
    n_br      = 0;
    rs1_p_d   = '0;
    rs2_p_d   = '0;
    rd_new_d  = '0;
    rd_old_d  = '0;
    tag_d     = '0;
    ckpt_id_d = '0;
    ckpt_we   = '0;
    ckpt_new  = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (dec_valid_i[l]) begin
        if (dec_rs1_used_i[l]) rs1_p_d[l] = map_next[dec_rs1_i[l]];
        if (dec_rs2_used_i[l]) rs2_p_d[l] = map_next[dec_rs2_i[l]];
        if (dec_rd_used_i[l])  rd_old_d[l] = map_next[dec_rd_i[l]];
        tag_d[l] = rob_tag_q + rob_tag_t'(n_valid);
        n_valid  = n_valid + 1;
        if (dec_rd_used_i[l] && dec_rd_i[l] != '0) begin
          rd_new_d[l]          = fl_pop_preg[n_alloc];
          map_next[dec_rd_i[l]] = rd_new_d[l];
          n_alloc              = n_alloc + 1;
        end else begin
          rd_new_d[l] = rd_old_d[l];
        end
        if (dec_is_branch_i[l]) begin
          ckpt_id_d[l]        = cq_tail_q + ckpt_id_t'(n_br);
          ckpt_we[l]          = 1'b1;
          ckpt_new[l].map     = map_next;
          ckpt_new[l].fl_head = fl_wrap(fl_head, n_alloc);
          ckpt_new[l].rob_tag = rob_tag_q + rob_tag_t'(n_valid);
          n_br                = n_br + 1;
        end
      end
    end
  end

  assign accept = (|dec_valid_i) && (!(|ren_valid_o) || ren_ready_i) &&
                  (n_alloc <= 32'(fl_count)) && (n_br <= N_CKPT - 32'(cq_count_q)) && !recover_i;
  assign dec_ready_o = accept;
  assign fl_pop_cnt  = accept ? ALLOC_W'(n_alloc) : '0;

  always_comb begin
    resolve_ok = resolve_i && (cq_count_q != '0);
    cq_head_d  = resolve_ok ? cq_head_q + ckpt_id_t'(1) : cq_head_q;
    cq_count_d = resolve_ok ? cq_count_q - CQ_CNT_W'(1) : cq_count_q;
    cq_tail_d  = cq_tail_q;
    if (recover_i) begin
      // Slot k stays live: the queue now runs from the (possibly advanced) head through k.
      cq_tail_d  = recover_ckpt_i + ckpt_id_t'(1);
      cq_count_d = CQ_CNT_W'(ckpt_id_t'(recover_ckpt_i - cq_head_d)) + CQ_CNT_W'(1);
    end else if (accept) begin
      cq_tail_d  = cq_tail_q + ckpt_id_t'(n_br);
      cq_count_d = cq_count_d + CQ_CNT_W'(n_br);
    end
  end

  rename_freelist u_fl (
    .clk          (clk),
    .rst          (rst),
    .pop_cnt      (fl_pop_cnt),
    .pop_preg     (fl_pop_preg),
    .push_valid   (commit_valid_i),
    .push_preg    (commit_preg_i),
    .restore      (recover_i),
    .restore_head (ckpt_q[recover_ckpt_i].fl_head),
    .head         (fl_head),
    .count        (fl_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LOG; i++) map_q[i] <= preg_t'(i);
      rob_tag_q   <= '0;
      cq_head_q   <= '0;
      cq_tail_q   <= '0;
      cq_count_q  <= '0;
      ren_valid_o <= '0;
      rs1_p_o     <= '0;
      rs2_p_o     <= '0;
      rd_new_p_o  <= '0;
      rd_old_p_o  <= '0;
      rob_tag_o   <= '0;
      ckpt_id_o   <= '0;
      payload_o   <= '0;
    end else begin
      cq_head_q  <= cq_head_d;
      cq_tail_q  <= cq_tail_d;
      cq_count_q <= cq_count_d;
      if (recover_i) begin
        map_q       <= ckpt_q[recover_ckpt_i].map;
        rob_tag_q   <= ckpt_q[recover_ckpt_i].rob_tag;
        ren_valid_o <= '0;
      end else if (accept) begin
        map_q       <= map_next;
        rob_tag_q   <= rob_tag_q + rob_tag_t'(n_valid);
        ren_valid_o <= dec_valid_i;
        rs1_p_o     <= rs1_p_d;
        rs2_p_o     <= rs2_p_d;
        rd_new_p_o  <= rd_new_d;
        rd_old_p_o  <= rd_old_d;
        rob_tag_o   <= tag_d;
        ckpt_id_o   <= ckpt_id_d;
        payload_o   <= dec_payload_i;
      end else if (ren_ready_i) begin
        ren_valid_o <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int l = 0; l < WIDTH; l++) begin
        if (ckpt_we[l]) ckpt_q[ckpt_id_d[l]] <= ckpt_new[l];
      end
    end
  end

  assign recover_live = CQ_CNT_W'(ckpt_id_t'(recover_ckpt_i - cq_head_q)) < cq_count_q;

  a_recover_live : assert property (@(posedge clk) disable iff (rst) recover_i |-> recover_live);

endmodule

// File: tb/tb_rename_wide.sv
// Directed bench for rename_wide: table of rename groups, then hand-written stall, recovery,
// checkpoint-full and free-list wrap sequences.
module tb_rename_wide;
  import pipeline_types::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [WIDTH-1:0]          dec_valid_i;
  lreg_t [WIDTH-1:0]         dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic [WIDTH-1:0]          dec_rs1_used_i, dec_rs2_used_i, dec_rd_used_i, dec_is_branch_i;
  ctrl_payload_t [WIDTH-1:0] dec_payload_i;
  logic                      dec_ready_o;
  logic [WIDTH-1:0]          ren_valid_o;
  logic                      ren_ready_i;
  preg_t [WIDTH-1:0]         rs1_p_o, rs2_p_o, rd_new_p_o, rd_old_p_o;
  rob_tag_t [WIDTH-1:0]      rob_tag_o;
  ckpt_id_t [WIDTH-1:0]      ckpt_id_o;
  ctrl_payload_t [WIDTH-1:0] payload_o;
  logic [COMMIT_W-1:0]       commit_valid_i;
  preg_t [COMMIT_W-1:0]      commit_preg_i;
  logic                      recover_i;
  ckpt_id_t                  recover_ckpt_i;
  logic                      resolve_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_wide dut (
    .clk             (clk),
    .rst             (rst),
    .dec_valid_i     (dec_valid_i),
    .dec_rs1_i       (dec_rs1_i),
    .dec_rs2_i       (dec_rs2_i),
    .dec_rd_i        (dec_rd_i),
    .dec_rs1_used_i  (dec_rs1_used_i),
    .dec_rs2_used_i  (dec_rs2_used_i),
    .dec_rd_used_i   (dec_rd_used_i),
    .dec_is_branch_i (dec_is_branch_i),
    .dec_payload_i   (dec_payload_i),
    .dec_ready_o     (dec_ready_o),
    .ren_valid_o     (ren_valid_o),
    .ren_ready_i     (ren_ready_i),
    .rs1_p_o         (rs1_p_o),
    .rs2_p_o         (rs2_p_o),
    .rd_new_p_o      (rd_new_p_o),
    .rd_old_p_o      (rd_old_p_o),
    .rob_tag_o       (rob_tag_o),
    .ckpt_id_o       (ckpt_id_o),
    .payload_o       (payload_o),
    .commit_valid_i  (commit_valid_i),
    .commit_preg_i   (commit_preg_i),
    .recover_i       (recover_i),
    .recover_ckpt_i  (recover_ckpt_i),
    .resolve_i       (resolve_i)
  );

  typedef struct packed {
    logic [1:0]      v;
    logic [1:0][4:0] rs1, rs2, rd;
    logic [1:0]      u1, u2, ud;
    logic [1:0][6:0] e_rs1, e_rs2, e_new, e_old, e_tag;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    dec_valid_i     = '0;
    dec_rs1_i       = '0;
    dec_rs2_i       = '0;
    dec_rd_i        = '0;
    dec_rs1_used_i  = '0;
    dec_rs2_used_i  = '0;
    dec_rd_used_i   = '0;
    dec_is_branch_i = '0;
    dec_payload_i   = '0;
    commit_valid_i  = '0;
    commit_preg_i   = '0;
    recover_i       = 1'b0;
    recover_ckpt_i  = '0;
    resolve_i       = 1'b0;
    ren_ready_i     = 1'b1;
  endtask

  task automatic lane(input int l, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit ud, input bit br);
    dec_valid_i[l]     = 1'b1;
    dec_rs1_i[l]       = lreg_t'(rs1);
    dec_rs1_used_i[l]  = u1;
    dec_rs2_i[l]       = lreg_t'(rs2);
    dec_rs2_used_i[l]  = u2;
    dec_rd_i[l]        = lreg_t'(rd);
    dec_rd_used_i[l]   = ud;
    dec_is_branch_i[l] = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int   fq[$];
  bit   inuse [N_PHYS];
  bit   pc_v [2];
  int   pc_p [2];
  int   head_m, tail_m, hw, tw, hw_m, prev_h, prev_t, exp_p;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v: 2'b11, rs1: {5'd5, 5'd1}, rs2: {5'd1, 5'd2}, rd: {5'd6, 5'd5},
               u1: 2'b11, u2: 2'b11, ud: 2'b11,
               e_rs1: {7'd32, 7'd1}, e_rs2: {7'd1, 7'd2}, e_new: {7'd33, 7'd32},
               e_old: {7'd6, 7'd5}, e_tag: {7'd1, 7'd0}};
    tbl[1] = '{v: 2'b11, rs1: {5'd7, 5'd6}, rs2: {5'd5, 5'd0}, rd: {5'd7, 5'd7},
               u1: 2'b11, u2: 2'b11, ud: 2'b11,
               e_rs1: {7'd34, 7'd33}, e_rs2: {7'd32, 7'd0}, e_new: {7'd35, 7'd34},
               e_old: {7'd34, 7'd7}, e_tag: {7'd3, 7'd2}};
    tbl[2] = '{v: 2'b01, rs1: {5'd0, 5'd7}, rs2: {5'd0, 5'd0}, rd: {5'd0, 5'd3},
               u1: 2'b01, u2: 2'b00, ud: 2'b00,
               e_rs1: {7'd0, 7'd35}, e_rs2: {7'd0, 7'd0}, e_new: {7'd0, 7'd0},
               e_old: {7'd0, 7'd0}, e_tag: {7'd0, 7'd4}};
    tbl[3] = '{v: 2'b10, rs1: {5'd5, 5'd0}, rs2: {5'd6, 5'd0}, rd: {5'd0, 5'd0},
               u1: 2'b10, u2: 2'b10, ud: 2'b10,
               e_rs1: {7'd32, 7'd0}, e_rs2: {7'd33, 7'd0}, e_new: {7'd0, 7'd0},
               e_old: {7'd0, 7'd0}, e_tag: {7'd5, 7'd0}};
    tbl[4] = '{v: 2'b11, rs1: {5'd8, 5'd7}, rs2: {5'd0, 5'd8}, rd: {5'd9, 5'd8},
               u1: 2'b11, u2: 2'b01, ud: 2'b11,
               e_rs1: {7'd36, 7'd35}, e_rs2: {7'd0, 7'd8}, e_new: {7'd37, 7'd36},
               e_old: {7'd9, 7'd8}, e_tag: {7'd7, 7'd6}};

    // Reset state.
    do_reset();
    check("reset_ren_valid", int'(ren_valid_o), 0);
    check("reset_dec_ready", int'(dec_ready_o), 0);
    check("reset_fl_count", int'(dut.fl_count), 64);
    check("reset_rd_new0", int'(rd_new_p_o[0]), 0);

    // Table-driven rename groups, including intra-group RAW/WAW bypass.
    for (int i = 0; i < 5; i++) begin
      clear_in();
      for (int l = 0; l < 2; l++) begin
        if (tbl[i].v[l]) begin
          lane(l, int'(tbl[i].rs1[l]), tbl[i].u1[l], int'(tbl[i].rs2[l]), tbl[i].u2[l],
               int'(tbl[i].rd[l]), tbl[i].ud[l], 1'b0);
          dec_payload_i[l] = '{opcode: 7'h33, funct3: 3'(l), imm: 32'(i * 16 + l)};
        end
      end
      #2;
      check($sformatf("v%0d_ready", i), int'(dec_ready_o), 1);
      tick();
      check($sformatf("v%0d_ren_valid", i), int'(ren_valid_o), int'(tbl[i].v));
      for (int l = 0; l < 2; l++) begin
        if (tbl[i].v[l]) begin
          check($sformatf("v%0d_l%0d_rs1", i, l), int'(rs1_p_o[l]), int'(tbl[i].e_rs1[l]));
          check($sformatf("v%0d_l%0d_rs2", i, l), int'(rs2_p_o[l]), int'(tbl[i].e_rs2[l]));
          check($sformatf("v%0d_l%0d_new", i, l), int'(rd_new_p_o[l]), int'(tbl[i].e_new[l]));
          check($sformatf("v%0d_l%0d_old", i, l), int'(rd_old_p_o[l]), int'(tbl[i].e_old[l]));
          check($sformatf("v%0d_l%0d_tag", i, l), int'(rob_tag_o[l]), int'(tbl[i].e_tag[l]));
          check($sformatf("v%0d_l%0d_payload", i, l), int'(payload_o[l].imm), i * 16 + l);
        end
      end
    end

    // Back-pressure: output holds, then the next group goes through.
    clear_in();
    ren_ready_i = 1'b0;
    lane(0, 9, 1'b1, 0, 1'b0, 10, 1'b1, 1'b0);
    #2;
    check("hold_ready", int'(dec_ready_o), 0);
    tick();
    check("hold_valid", int'(ren_valid_o), 3);
    check("hold_rd_new0", int'(rd_new_p_o[0]), 36);
    ren_ready_i = 1'b1;
    #2;
    check("release_ready", int'(dec_ready_o), 1);
    tick();
    check("release_rs1", int'(rs1_p_o[0]), 37);
    check("release_rd_new", int'(rd_new_p_o[0]), 38);
    check("release_tag", int'(rob_tag_o[0]), 8);
    clear_in();
    tick();
    check("drain_clear_valid", int'(ren_valid_o), 0);

    // Drain the free list to one entry, stall a two-allocation group, then free one preg.
    do_reset();
    for (int g = 0; g < 32; g++) begin
      clear_in();
      lane(0, 0, 1'b0, 0, 1'b0, 1 + g % 31, 1'b1, 1'b0);
      if (g < 31) lane(1, 0, 1'b0, 0, 1'b0, 1 + (g + 1) % 31, 1'b1, 1'b0);
      tick();
    end
    check("drain_count", int'(dut.fl_count), 1);
    clear_in();
    lane(0, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0);
    lane(1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0);
    #2;
    check("empty_stall_ready", int'(dec_ready_o), 0);
    tick();
    check("empty_stall_count", int'(dut.fl_count), 1);
    check("empty_stall_rob", int'(dut.rob_tag_q), 63);
    check("empty_stall_valid", int'(ren_valid_o), 0);
    commit_valid_i = 2'b11;
    commit_preg_i[0] = preg_t'(5);
    commit_preg_i[1] = preg_t'(0);
    #2;
    check("commit_cycle_ready", int'(dec_ready_o), 0);
    tick();
    commit_valid_i = '0;
    check("commit_count", int'(dut.fl_count), 2);
    #2;
    check("after_commit_ready", int'(dec_ready_o), 1);
    tick();
    check("after_commit_new0", int'(rd_new_p_o[0]), 95);
    check("after_commit_new1", int'(rd_new_p_o[1]), 5);
    check("after_commit_count", int'(dut.fl_count), 0);

    // Branch checkpoint then recovery to it with a same-cycle commit.
    do_reset();
    lane(0, 1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
    lane(1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0);
    #2;
    check("br_ready", int'(dec_ready_o), 1);
    tick();
    check("br_ckpt_id", int'(ckpt_id_o[0]), 0);
    check("br_lane1_new", int'(rd_new_p_o[1]), 32);
    check("br_lane1_tag", int'(rob_tag_o[1]), 1);
    clear_in();
    recover_i        = 1'b1;
    recover_ckpt_i   = '0;
    commit_valid_i   = 2'b01;
    commit_preg_i[0] = preg_t'(40);
    lane(0, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
    #2;
    check("recover_no_accept", int'(dec_ready_o), 0);
    tick();
    clear_in();
    check("recover_valid_clear", int'(ren_valid_o), 0);
    check("recover_rob_tag", int'(dut.rob_tag_q), 1);
    check("recover_fl_head", int'(dut.fl_head), 0);
    check("recover_fl_count", int'(dut.fl_count), 65);
    check("recover_cq_count", int'(dut.cq_count_q), 1);
    lane(0, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
    #2;
    check("post_recover_ready", int'(dec_ready_o), 1);
    tick();
    check("post_recover_map5", int'(rs1_p_o[0]), 5);
    check("post_recover_new", int'(rd_new_p_o[0]), 32);
    check("post_recover_tag", int'(rob_tag_o[0]), 1);

    // Fill all checkpoints, stall a branch, resolve, then the branch takes slot 0.
    do_reset();
    for (int g = 0; g < 4; g++) begin
      clear_in();
      lane(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      lane(1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      tick();
      check($sformatf("fill%0d_id0", g), int'(ckpt_id_o[0]), 2 * g);
      check($sformatf("fill%0d_id1", g), int'(ckpt_id_o[1]), 2 * g + 1);
    end
    clear_in();
    lane(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    resolve_i = 1'b1;
    #2;
    check("ckpt_full_stall", int'(dec_ready_o), 0);
    tick();
    resolve_i = 1'b0;
    #2;
    check("after_resolve_ready", int'(dec_ready_o), 1);
    tick();
    check("wrap_ckpt_id", int'(ckpt_id_o[0]), 0);
    check("wrap_ckpt_tag", int'(rob_tag_o[0]), 8);
    check("wrap_cq_count", int'(dut.cq_count_q), 8);

    // Free-list wrap: allocate and commit continuously against a FIFO model.
    do_reset();
    fq.delete();
    for (int p = 0; p < N_PHYS; p++) begin
      inuse[p] = (p < N_LOG);
      if (p >= N_LOG) fq.push_back(p);
    end
    head_m = 0;
    tail_m = N_PHYS - N_LOG;
    hw = 0; tw = 0; hw_m = 0;
    prev_h = 0; prev_t = tail_m;
    pc_v[0] = 1'b0; pc_v[1] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      clear_in();
      lane(0, 0, 1'b0, 0, 1'b0, 1 + c % 31, 1'b1, 1'b0);
      if (c % 2 == 1) lane(1, 0, 1'b0, 0, 1'b0, 1 + (c + 7) % 31, 1'b1, 1'b0);
      for (int j = 0; j < 2; j++) begin
        commit_valid_i[j] = pc_v[j];
        commit_preg_i[j]  = preg_t'(pc_p[j]);
      end
      #2;
      check("wrap_ready", int'(dec_ready_o), 1);
      tick();
      for (int j = 0; j < 2; j++) begin
        if (pc_v[j]) begin
          fq.push_back(pc_p[j]);
          inuse[pc_p[j]] = 1'b0;
          tail_m = (tail_m + 1) % N_PHYS;
        end
      end
      for (int l = 0; l < 2; l++) begin
        pc_v[l] = 1'b0;
        if (dec_valid_i[l]) begin
          exp_p = fq.pop_front();
          check("wrap_rd_new", int'(rd_new_p_o[l]), exp_p);
          check("wrap_no_dup", int'(inuse[rd_new_p_o[l]] || rd_new_p_o[l] == '0), 0);
          inuse[rd_new_p_o[l]] = 1'b1;
          if (head_m == N_PHYS - 1) hw_m++;
          head_m = (head_m + 1) % N_PHYS;
          pc_v[l] = 1'b1;
          pc_p[l] = int'(rd_old_p_o[l]);
        end
      end
      check("wrap_fl_head", int'(dut.fl_head), head_m);
      check("wrap_fl_tail", int'(dut.u_fl.tail_q), tail_m);
      if (int'(dut.fl_head) < prev_h) hw++;
      if (int'(dut.u_fl.tail_q) < prev_t) tw++;
      prev_h = int'(dut.fl_head);
      prev_t = int'(dut.u_fl.tail_q);
    end
    check("head_wraps", hw, hw_m);
    check("tail_wrapped", int'(tw > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
